// File: rtl/h14tx_reset_seq_pkg.sv
// Shared FSM encoding for the HDMI TX multi-channel reset sequencer.
package h14tx_reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_GUARD     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/h14tx_sync2.sv
// Generic two-flop synchroniser for signals crossing into clk; deliberately unreset.
module h14tx_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;

    // Two-stage capture; the first stage may go metastable
    always_ff @(posedge clk) begin
        meta_r <= d;
        q      <= meta_r;
    end

endmodule

// File: rtl/h14tx_reset_seq.sv
// Multi-channel reset sequencer: waits for stable PLL lock, a guard interval, then releases
// channels in a staggered order. Optional status ports enabled by H14TX_RESET_SEQ_STATUS_EN.
module h14tx_reset_seq
    import h14tx_reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int GUARD_W     = 4,
    parameter int STAGE_GAP   = 8,
    parameter int LOCK_FILTER = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    input  logic               soft_rst,
    output logic [NUM_CH-1:0]  sync_rst_n,
`ifdef H14TX_RESET_SEQ_STATUS_EN
    output logic [7:0]         relock_cnt,
    output logic [STATE_W-1:0] state_o,
`endif
    output logic               done
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int STG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0]  STAGE_LAST = STG_W'(NUM_CH - 1);

    state_t              state_r;
    logic [FILT_W-1:0]   filt_cnt_r;
    logic [GUARD_W-1:0]  guard_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [STG_W-1:0]    stage_r;
    logic                lock_s;
    logic                abort_s;

    // Channels are released in index order, so the next mask just shifts in another one
    function automatic logic [NUM_CH-1:0] fill_next(input logic [NUM_CH-1:0] mask);
        return (mask << 1) | NUM_CH'(1'b1);
    endfunction

    h14tx_sync2 #(.W(1)) u_lock_sync (
        .clk (clk),
        .d   (lock),
        .q   (lock_s)
    );

    // Abort request: soft reset anywhere past Assert, lock loss once the filter has qualified lock
    always_comb begin
        abort_s = 1'b0;
        if (state_r == ST_ASSERT) begin
            abort_s = 1'b0;
        end else if (soft_rst) begin
            abort_s = 1'b1;
        end else if (!lock_s && (state_r != ST_WAIT_LOCK)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Sequencer FSM with registered reset outputs and done flag
    always_ff @(posedge clk) begin
        if (rst || abort_s) begin
            state_r     <= ST_ASSERT;
            sync_rst_n  <= '0;
            done        <= 1'b0;
            filt_cnt_r  <= '0;
            guard_cnt_r <= '0;
            gap_cnt_r   <= '0;
            stage_r     <= '0;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    sync_rst_n  <= '0;
                    done        <= 1'b0;
                    filt_cnt_r  <= '0;
                    guard_cnt_r <= '0;
                    gap_cnt_r   <= '0;
                    stage_r     <= '0;
                    state_r     <= soft_rst ? ST_ASSERT : ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        filt_cnt_r <= '0;
                    end else if (filt_cnt_r == FILT_LAST) begin
                        filt_cnt_r <= '0;
                        state_r    <= ST_GUARD;
                    end else begin
                        filt_cnt_r <= filt_cnt_r + FILT_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt_r == '1) begin
                        guard_cnt_r <= '0;
                        gap_cnt_r   <= '0;
                        stage_r     <= '0;
                        sync_rst_n  <= fill_next(sync_rst_n);
                        state_r     <= ST_RELEASE;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + GUARD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // A single-channel build has nothing left to stagger after entry
                    if (stage_r == STAGE_LAST) begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r  <= '0;
                        stage_r    <= stage_r + STG_W'(1);
                        sync_rst_n <= fill_next(sync_rst_n);
                        if ((stage_r + STG_W'(1)) == STAGE_LAST) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            done    <= 1'b0;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state_r    <= ST_ASSERT;
                    sync_rst_n <= '0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef H14TX_RESET_SEQ_STATUS_EN
    logic lock_loss_s;

    // Only lock losses past the filter are counted; soft reset has priority over lock loss
    always_comb begin
        lock_loss_s = 1'b0;
        if (soft_rst || lock_s) begin
            lock_loss_s = 1'b0;
        end else if ((state_r == ST_GUARD) || (state_r == ST_RELEASE) || (state_r == ST_DONE)) begin
            lock_loss_s = 1'b1;
        end else begin
            lock_loss_s = 1'b0;
        end
    end

    // Saturating relock counter, cleared only by hard reset
    always_ff @(posedge clk) begin
        if (rst) begin
            relock_cnt <= 8'd0;
        end else if (lock_loss_s && (relock_cnt != 8'hFF)) begin
            relock_cnt <= relock_cnt + 8'd1;
        end else begin
            relock_cnt <= relock_cnt;
        end
    end

    assign state_o = state_r;
`endif

endmodule

// File: tb/tb_h14tx_reset_seq.sv
// Directed self-checking bench for h14tx_reset_seq at default parameters.
module tb_h14tx_reset_seq;
    import h14tx_reset_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       soft_rst;
    logic [3:0] sync_rst_n;
    logic       done;
`ifdef H14TX_RESET_SEQ_STATUS_EN
    logic [7:0] relock_cnt;
    logic [2:0] state_o;
`endif

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    h14tx_reset_seq dut (
        .clk        (clk),
        .rst        (rst),
        .lock       (lock),
        .soft_rst   (soft_rst),
        .sync_rst_n (sync_rst_n),
`ifdef H14TX_RESET_SEQ_STATUS_EN
        .relock_cnt (relock_cnt),
        .state_o    (state_o),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        edge_n = edge_n + 1;
        #1;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 0;
        while (!done && budget < 80) begin
            tick();
            budget = budget + 1;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; lock = 1'b1; soft_rst = 1'b0;
        repeat (4) tick();
        chk("rst_sync", {28'd0, sync_rst_n}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_state", {29'd0, dut.state_r}, {29'd0, ST_ASSERT});

        // Test 1: nominal release timing
        rst = 1'b0; edge_n = 0;
        run_to(19); chk("t1_e19", {28'd0, sync_rst_n}, 32'h0);
        run_to(20); chk("t1_e20", {28'd0, sync_rst_n}, 32'h1);
        run_to(27); chk("t1_e27", {28'd0, sync_rst_n}, 32'h1);
        run_to(28); chk("t1_e28", {28'd0, sync_rst_n}, 32'h3);
        run_to(35); chk("t1_e35", {28'd0, sync_rst_n}, 32'h3);
        run_to(36); chk("t1_e36", {28'd0, sync_rst_n}, 32'h7);
        run_to(43); chk("t1_e43", {28'd0, sync_rst_n}, 32'h7);
        chk("t1_done43", {31'd0, done}, 32'd0);
        run_to(44); chk("t1_e44", {28'd0, sync_rst_n}, 32'hF);
        chk("t1_done44", {31'd0, done}, 32'd1);

        // Test 2: one-cycle lock glitch after two filtered-high cycles
        do_reset();
        run_to(1); lock = 1'b0;
        run_to(2); lock = 1'b1;
        run_to(22); chk("t2_e22", {28'd0, sync_rst_n}, 32'h0);
        run_to(23); chk("t2_e23", {28'd0, sync_rst_n}, 32'h1);

        // Test 3: lock loss with two channels released
        run_to(31); chk("t3_e31", {28'd0, sync_rst_n}, 32'h3);
        lock = 1'b0;
        run_to(33); chk("t3_e33", {28'd0, sync_rst_n}, 32'h3);
        run_to(34); chk("t3_e34", {28'd0, sync_rst_n}, 32'h0);
        chk("t3_done34", {31'd0, done}, 32'd0);
        lock = 1'b1;
        run_to(54); chk("t3_e54", {28'd0, sync_rst_n}, 32'h0);
        run_to(55); chk("t3_e55", {28'd0, sync_rst_n}, 32'h1);
        run_to(78); chk("t3_done78", {31'd0, done}, 32'd0);
        run_to(79); chk("t3_e79", {28'd0, sync_rst_n}, 32'hF);
        chk("t3_done79", {31'd0, done}, 32'd1);

        // Test 4: soft reset pulse in Done, then held soft reset
        run_to(81); chk("t4_e81", {28'd0, sync_rst_n}, 32'hF);
        soft_rst = 1'b1;
        run_to(82); soft_rst = 1'b0;
        chk("t4_e82", {28'd0, sync_rst_n}, 32'h0);
        chk("t4_done82", {31'd0, done}, 32'd0);
        run_to(101); chk("t4_e101", {28'd0, sync_rst_n}, 32'h0);
        run_to(102); chk("t4_e102", {28'd0, sync_rst_n}, 32'h1);
        soft_rst = 1'b1;
        run_to(103); chk("t4_hold103", {28'd0, sync_rst_n}, 32'h0);
        run_to(107); chk("t4_hold107", {28'd0, sync_rst_n}, 32'h0);
        chk("t4_hold_state", {29'd0, dut.state_r}, {29'd0, ST_ASSERT});
        soft_rst = 1'b0;
        run_to(126); chk("t4_e126", {28'd0, sync_rst_n}, 32'h0);
        run_to(127); chk("t4_e127", {28'd0, sync_rst_n}, 32'h1);

        // Test 5: hard reset mid-Guard wins over soft reset and lock loss
        do_reset();
        run_to(10); chk("t5_guard", {29'd0, dut.state_r}, {29'd0, ST_GUARD});
        rst = 1'b1; soft_rst = 1'b1; lock = 1'b0;
        tick();
        chk("t5_sync", {28'd0, sync_rst_n}, 32'h0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_state", {29'd0, dut.state_r}, {29'd0, ST_ASSERT});
        chk("t5_guard_cnt", {28'd0, dut.guard_cnt_r}, 32'd0);
        chk("t5_filt_cnt", {30'd0, dut.filt_cnt_r}, 32'd0);
        chk("t5_stage", {30'd0, dut.stage_r}, 32'd0);
        lock = 1'b1; soft_rst = 1'b0;
        repeat (3) tick();
        rst = 1'b0; edge_n = 0;
        run_to(19); chk("t5_e19", {28'd0, sync_rst_n}, 32'h0);
        run_to(20); chk("t5_e20", {28'd0, sync_rst_n}, 32'h1);

`ifdef H14TX_RESET_SEQ_STATUS_EN
        // Test 6: relock counter counts and saturates
        do_reset();
        chk("t6_cnt0", {24'd0, relock_cnt}, 32'd0);
        run_to(44); chk("t6_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            lock = 1'b0;
            repeat (3) tick();
            lock = 1'b1;
            wait_done("t6_redone");
            if (i == 2) chk("t6_cnt3", {24'd0, relock_cnt}, 32'd3);
        end
        chk("t6_cnt255", {24'd0, relock_cnt}, 32'd255);
        chk("t6_state_o", {29'd0, state_o}, {29'd0, ST_DONE});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
